// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data-path word type, PC increment,
// reset/bubble defaults and the next-PC source selector used by fetch.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t PC_INC            = 32'd4;
    localparam word_t NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
    localparam word_t RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_PC4,
        SEL_BRANCH,
        SEL_JUMP
    } next_pc_sel_t;

    // Clears the byte-offset bits so every PC stays word aligned.
    function automatic word_t word_align(input word_t a);
        return a & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_addr  : fetch address (driven by fetch, master)
//   imem_rdata : instruction word, combinational read of imem_addr (slave)
interface fetch_stage_if;
    import mips_pkg::*;

    word_t imem_addr;
    word_t imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction word, PC+4 and valid flag.
//   clk_i, rst_i : clock, synchronous active-high reset
//   hold_i       : keep current contents (stall)
//   bubble_i     : load NOP_INSTR with valid cleared (squash)
//   instr_i      : fetched instruction word
//   pc4_i        : PC+4 of the fetched instruction
//   dinstr_o, dpc4_o, dvalid_o : registered IF/ID contents
module if_id_reg
    import mips_pkg::*;
#(
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter word_t RESET_PC4 = RESET_PC_DEFAULT + PC_INC
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  hold_i,
    input  logic  bubble_i,
    input  word_t instr_i,
    input  word_t pc4_i,
    output word_t dinstr_o,
    output word_t dpc4_o,
    output logic  dvalid_o
);

    word_t dinstr_q, dinstr_d;
    word_t dpc4_q,   dpc4_d;
    logic  dvalid_q, dvalid_d;

    always_comb begin
        dinstr_d = dinstr_q;
        dpc4_d   = dpc4_q;
        dvalid_d = dvalid_q;
        if (!hold_i) begin
            // dpc4 loads even on a bubble; it is don't-care while dvalid=0.
            dpc4_d = pc4_i;
            if (bubble_i) begin
                dinstr_d = NOP_INSTR;
                dvalid_d = 1'b0;
            end else begin
                dinstr_d = instr_i;
                dvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dinstr_q <= NOP_INSTR;
            dpc4_q   <= RESET_PC4;
            dvalid_q <= 1'b0;
        end else begin
            dinstr_q <= dinstr_d;
            dpc4_q   <= dpc4_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign dinstr_o = dinstr_q;
    assign dpc4_o   = dpc4_q;
    assign dvalid_o = dvalid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC select
// (jump > branch > PC+4) and the IF/ID register.
//   clk, rst      : clock, synchronous active-high reset (dominates all)
//   stall         : freeze PC and IF/ID; redirects ignored while set
//   branch_taken, bpc : taken branch and its target from decode
//   jump, jpc     : j/jal and its target from decode
//   imem          : instruction-memory bus (imem_addr = pc)
//   pc            : current fetch PC
//   dinstr, dpc4, dvalid : IF/ID contents (dvalid=0 marks a bubble)
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch / perf_stall counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter word_t RESET_PC  = RESET_PC_DEFAULT,
    parameter word_t NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  branch_taken,
    input  word_t bpc,
    input  logic  jump,
    input  word_t jpc,
    fetch_stage_if.master imem,
    output word_t pc,
    output word_t dinstr,
    output word_t dpc4,
    output logic  dvalid
`ifdef FETCH_PERF_CNT_EN
    ,
    output word_t perf_fetch,
    output word_t perf_stall
`endif
);

    word_t        pc_q, pc_d;
    word_t        pc4;
    word_t        target;
    next_pc_sel_t sel;
    logic         redirect;

    assign pc4      = pc_q + PC_INC;  // wraps modulo 2^32
    assign redirect = jump | branch_taken;

    always_comb begin
        sel = SEL_PC4;
        if (jump) begin
            sel = SEL_JUMP;
        end else if (branch_taken) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        case (sel)
            SEL_JUMP:   target = word_align(jpc);
            SEL_BRANCH: target = word_align(bpc);
            default:    target = pc4;
        endcase
        pc_d = stall ? pc_q : target;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc             = pc_q;
    assign imem.imem_addr = pc_q;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR),
        .RESET_PC4 (RESET_PC + PC_INC)
    ) u_if_id (
        .clk_i    (clk),
        .rst_i    (rst),
        .hold_i   (stall),
        .bubble_i (redirect),
        .instr_i  (imem.imem_rdata),
        .pc4_i    (pc4),
        .dinstr_o (dinstr),
        .dpc4_o   (dpc4),
        .dvalid_o (dvalid)
    );

`ifdef FETCH_PERF_CNT_EN
    word_t perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end else if (!redirect) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import mips_pkg::*;

    typedef struct {
        logic  rst;
        logic  stall;
        logic  jump;
        logic  br;
        word_t bpc;
        word_t jpc;
        word_t pc;
        word_t dinstr;
        word_t dpc4;
        logic  chk_dpc4;
        logic  dvalid;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  stall = 1'b0;
    logic  jump = 1'b0;
    logic  branch_taken = 1'b0;
    word_t bpc = '0;
    word_t jpc = '0;
    word_t pc, dinstr, dpc4;
    logic  dvalid;
`ifdef FETCH_PERF_CNT_EN
    word_t perf_fetch, perf_stall;
    word_t exp_fetch = '0;
    word_t exp_stall = '0;
`endif

    int tests = 0;
    int fails = 0;
    vec_t sb_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    function automatic word_t mem(input word_t a);
        return a ^ 32'hC0DE_0000;
    endfunction

    fetch_stage_if bus ();
    assign bus.imem_rdata = mem(bus.imem_addr);

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .bpc          (bpc),
        .jump         (jump),
        .jpc          (jpc),
        .imem         (bus),
        .pc           (pc),
        .dinstr       (dinstr),
        .dpc4         (dpc4),
        .dvalid       (dvalid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch   (perf_fetch),
        .perf_stall   (perf_stall)
`endif
    );

    function automatic vec_t mk(input logic r, input logic s, input logic j,
                                input logic b, input word_t bp, input word_t jp,
                                input word_t e_pc, input word_t e_di,
                                input word_t e_d4, input logic cd, input logic ev);
        vec_t v;
        v.rst = r; v.stall = s; v.jump = j; v.br = b; v.bpc = bp; v.jpc = jp;
        v.pc = e_pc; v.dinstr = e_di; v.dpc4 = e_d4; v.chk_dpc4 = cd; v.dvalid = ev;
        return v;
    endfunction

    task automatic check(input string name, input word_t act, input word_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; stall = v.stall; jump = v.jump; branch_taken = v.br;
        bpc = v.bpc; jpc = v.jpc;
        sb_q.push_back(v);
`ifdef FETCH_PERF_CNT_EN
        if (v.rst) begin
            exp_fetch = '0;
            exp_stall = '0;
        end else if (v.stall) begin
            exp_stall = exp_stall + 32'd1;
        end else if (!(v.jump || v.br)) begin
            exp_fetch = exp_fetch + 32'd1;
        end
`endif
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, " pc"}, pc, e.pc);
        check({tag, " imem_addr"}, bus.imem_addr, e.pc);
        check({tag, " dinstr"}, dinstr, e.dinstr);
        if (e.chk_dpc4) check({tag, " dpc4"}, dpc4, e.dpc4);
        check({tag, " dvalid"}, {31'b0, dvalid}, {31'b0, e.dvalid});
`ifdef FETCH_PERF_CNT_EN
        check({tag, " perf_fetch"}, perf_fetch, exp_fetch);
        check({tag, " perf_stall"}, perf_stall, exp_stall);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // reset, then straight-line fetch
        tbl.push_back(mk(1,0,0,0, 0, 0, 32'h0,   32'h0,            32'h4,   1, 0));
        tbl.push_back(mk(1,0,0,0, 0, 0, 32'h0,   32'h0,            32'h4,   1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h4,   mem(32'h0),       32'h4,   1, 1));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h8,   mem(32'h4),       32'h8,   1, 1));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'hC,   mem(32'h8),       32'hC,   1, 1));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h10,  mem(32'hC),       32'h10,  1, 1));
        // taken branch at 0x10
        tbl.push_back(mk(0,0,0,1, 32'h40, 0, 32'h40, 32'h0,        32'h0,   0, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h44,  mem(32'h40),      32'h44,  1, 1));
        // jump beats branch
        tbl.push_back(mk(0,0,1,1, 32'h200, 32'h100, 32'h100, 32'h0, 32'h0,  0, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h104, mem(32'h100),     32'h104, 1, 1));
        // reach 0x20, then stall with a pending branch
        tbl.push_back(mk(0,0,1,0, 0, 32'h1C, 32'h1C, 32'h0,        32'h0,   0, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h20,  mem(32'h1C),      32'h20,  1, 1));
        tbl.push_back(mk(0,1,0,1, 32'h80, 0, 32'h20, mem(32'h1C),  32'h20,  1, 1));
        tbl.push_back(mk(0,1,0,1, 32'h80, 0, 32'h20, mem(32'h1C),  32'h20,  1, 1));
        tbl.push_back(mk(0,1,0,1, 32'h80, 0, 32'h20, mem(32'h1C),  32'h20,  1, 1));
        tbl.push_back(mk(0,0,0,1, 32'h80, 0, 32'h80, 32'h0,        32'h0,   0, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h84,  mem(32'h80),      32'h84,  1, 1));
        // misaligned branch target
        tbl.push_back(mk(0,0,0,1, 32'h43, 0, 32'h40, 32'h0,        32'h0,   0, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h44,  mem(32'h40),      32'h44,  1, 1));
        // misaligned jump to top of memory, then wrap
        tbl.push_back(mk(0,0,1,0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h0,   mem(32'hFFFF_FFFC), 32'h0, 1, 1));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h4,   mem(32'h0),       32'h4,   1, 1));
        // reset dominates stall and jump
        tbl.push_back(mk(1,1,1,0, 0, 32'h300, 32'h0, 32'h0,        32'h4,   1, 0));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h4,   mem(32'h0),       32'h4,   1, 1));
        // plain stall
        tbl.push_back(mk(0,1,0,0, 0, 0, 32'h4,   mem(32'h0),       32'h4,   1, 1));
        tbl.push_back(mk(0,0,0,0, 0, 0, 32'h8,   mem(32'h4),       32'h8,   1, 1));

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // held jump under a two-cycle stall is taken once the stall drops
        step("hold_j0", mk(0,1,1,0, 0, 32'h200, 32'h8,   mem(32'h4),   32'h8,   1, 1));
        step("hold_j1", mk(0,1,1,0, 0, 32'h200, 32'h8,   mem(32'h4),   32'h8,   1, 1));
        step("hold_j2", mk(0,0,1,0, 0, 32'h200, 32'h200, 32'h0,        32'h0,   0, 0));
        step("hold_j3", mk(0,0,0,0, 0, 0,       32'h204, mem(32'h200), 32'h204, 1, 1));

        // back-to-back redirects: branch then jump, both squashed
        step("b2b_0", mk(0,0,0,1, 32'h500, 0,   32'h500, 32'h0,        32'h0,   0, 0));
        step("b2b_1", mk(0,0,1,0, 0, 32'h600,   32'h600, 32'h0,        32'h0,   0, 0));
        step("b2b_2", mk(0,0,0,0, 0, 0,         32'h604, mem(32'h600), 32'h604, 1, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
